keycode_fifo_pio: RTL
=====================

KEYCODE_FIFO_PIO -- requirements
Module: keycode_fifo_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning keycode width in bits, legal range 8..32.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries, power of two, legal range 2..128.
REQ-003 SHALL have port clk, input, 1 bit, meaning clock: all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port address, input, 2 bits, meaning Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1 bit, meaning slave select.
REQ-007 SHALL have port write_n, input, 1 bit, meaning active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits, meaning write data.
REQ-009 SHALL have port readdata, output, 32 bits, meaning read data, combinational, read latency 0.
REQ-010 SHALL have port out_port, output, DATA_W bits, meaning last keycode written.
REQ-011 SHALL have port st_data, output, DATA_W bits, meaning FIFO head.
REQ-012 SHALL have port st_valid, output, 1 bit, meaning FIFO non-empty.
REQ-013 SHALL have port st_ready, input, 1 bit, meaning consumer accepts head.
REQ-014 SHALL have port irq, output, 1 bit, meaning interrupt; present only with KEYCODE_FIFO_IRQ_EN.

Function
REQ-015 SHALL treat a write as chipselect & ~write_n in one cycle; reads have no side effects.
REQ-016 SHALL decode the register map as follows: addr 0 DATA, addr 1 STATUS, addr 2 CONTROL, addr 3 reserved (reads 0, writes ignored).
REQ-017 SHALL, on a DATA write, load writedata[DATA_W-1:0] into out_port regardless of FIFO state.
REQ-018 SHALL, on a DATA write when not full, push the word into the FIFO.
REQ-019 SHALL, on a DATA write when full and no pop occurs that cycle, drop the word and set the sticky overflow flag.
REQ-020 SHALL, on a DATA write when full and a pop occurs the same cycle, accept the push with no overflow.
REQ-021 SHALL return out_port zero-extended to 32 bits on a DATA read.
REQ-022 SHALL return STATUS as: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count, all other bits 0.
REQ-023 SHALL clear overflow on a STATUS write with writedata[2]=1; other STATUS bits are read-only.
REQ-024 SHALL flush the FIFO at the next edge on a CONTROL write with writedata[0]=1; bit0 reads 0.
REQ-025 SHALL give flush priority over a same-cycle pop; out_port and overflow are unaffected by flush.
REQ-026 SHALL drive st_valid = ~empty and st_data = oldest entry; a pop occurs when st_valid & st_ready.
REQ-027 SHALL have no bypass: a word pushed into an empty FIFO appears on st_valid one cycle after the write edge.
REQ-028 SHALL leave count unchanged on a simultaneous push and pop at non-full, non-empty; count = 0..DEPTH.
REQ-029 SHALL wrap pointers modulo DEPTH; a pop while empty is impossible, since st_valid is 0.

Reset
REQ-030 SHALL, while reset_n=0, clear out_port, pointers, count, overflow and irq_en immediately.
REQ-031 SHALL hold st_valid=0, irq=0, STATUS=0x00000001 after reset, including a reset asserted mid-transfer.

Configuration
REQ-032 SHALL, with KEYCODE_FIFO_IRQ_EN defined, implement CONTROL bit1 as irq_en (read/write) and drive irq = irq_en & overflow as a level.
REQ-033 SHALL, without KEYCODE_FIFO_IRQ_EN, omit the irq port; CONTROL bit1 reads 0 and writes to it are ignored.

Structure
REQ-034 SHALL place register address constants, STATUS/CONTROL bit positions and the count field position in package keycode_fifo_pkg.
REQ-035 SHALL implement storage and pointers in one sub-module keycode_fifo_mem (sync FIFO: push, pop, flush, head, count); the top level holds the Avalon decode and registers.

Verification
REQ-036 SHALL cover: reset, then read addr1 -> 0x00000001; st_valid=0; out_port=0.
REQ-037 SHALL cover: write 0x1A to addr0 with st_ready=0 -> out_port=0x1A; st_valid=1 next cycle; st_data=0x1A; count=1.
REQ-038 SHALL cover: 9 writes 1..9 with DEPTH=8 and st_ready=0 -> full=1, overflow=1, 9 dropped; drain yields 1..8 in order.
REQ-039 SHALL cover: FIFO full with st_ready=1 and a write of 0x55 in the same cycle -> accepted, overflow stays 0, count stays 8.
REQ-040 SHALL cover: write 1 to addr2 with 3 entries -> next cycle empty=1, count=0; out_port retains its last value.
REQ-041 SHALL cover, with KEYCODE_FIFO_IRQ_EN: set irq_en, force overflow -> irq=1; write 0x4 to addr1 -> irq=0 next cycle.

Source files
------------

// File: rtl/keycode_fifo_pkg.sv
// Register map, STATUS/CONTROL bit positions and count field placement for keycode_fifo_pio.
package keycode_fifo_pkg;

  typedef enum logic [1:0] {
    RegData    = 2'd0,
    RegStatus  = 2'd1,
    RegControl = 2'd2,
    RegRsvd    = 2'd3
  } reg_addr_e;

  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusCountLsb = 8;
  localparam int unsigned StatusCountW   = 8;

  localparam int unsigned CtrlFlushBit = 0;
  localparam int unsigned CtrlIrqEnBit = 1;

endpackage

// File: rtl/keycode_fifo_mem.sv
// Synchronous keycode FIFO: storage, wrapping pointers and occupancy count.
// Flush wins over push/pop; a push into a full FIFO is accepted only alongside a pop.
module keycode_fifo_mem
  import keycode_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/keycode_fifo_pio.sv
// Avalon-MM keycode PIO with a streaming FIFO: DATA/STATUS/CONTROL decode and registers.
// Define KEYCODE_FIFO_IRQ_EN to add the irq port and the CONTROL irq_en bit.
module keycode_fifo_pio
  import keycode_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
`ifdef KEYCODE_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  logic [DATA_W-1:0]       out_port_q, out_port_d;
  logic                    overflow_q, overflow_d;
  logic                    wr_en, data_we, status_we, control_we;
  logic                    flush, pop, empty, full;
  logic [$clog2(DEPTH):0]  count;
  logic                    unused_wdata;

  assign wr_en      = chipselect & ~write_n;
  assign data_we    = wr_en & (reg_addr_e'(address) == RegData);
  assign status_we  = wr_en & (reg_addr_e'(address) == RegStatus);
  assign control_we = wr_en & (reg_addr_e'(address) == RegControl);
  assign flush      = control_we & writedata[CtrlFlushBit];
  assign pop        = st_valid & st_ready;
  assign unused_wdata = ^writedata;

  keycode_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_we),
    .pop     (pop),
    .flush   (flush),
    .wdata   (writedata[DATA_W-1:0]),
    .head    (st_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign st_valid = ~empty;
  assign out_port = out_port_q;

  always_comb begin
    out_port_d = out_port_q;
    overflow_d = overflow_q;
    if (data_we) out_port_d = writedata[DATA_W-1:0];
    // Drop only when no slot frees up this cycle.
    if (data_we && full && !pop) overflow_d = 1'b1;
    if (status_we && writedata[StatusOvfBit]) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      out_port_q <= out_port_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef KEYCODE_FIFO_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (control_we) irq_en_d = writedata[CtrlIrqEnBit];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_en_q <= 1'b0;
    else          irq_en_q <= irq_en_d;
  end

  assign irq = irq_en_q & overflow_q;
`endif

  always_comb begin
    readdata = '0;
    unique case (reg_addr_e'(address))
      RegData: readdata = 32'(out_port_q);
      RegStatus: begin
        readdata[StatusEmptyBit] = empty;
        readdata[StatusFullBit]  = full;
        readdata[StatusOvfBit]   = overflow_q;
        readdata[StatusCountLsb +: StatusCountW] = 8'(count);
      end
      RegControl: begin
`ifdef KEYCODE_FIFO_IRQ_EN
        readdata[CtrlIrqEnBit] = irq_en_q;
`endif
      end
      default: readdata = '0;
    endcase
  end

endmodule
